// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage RV32I immediate packer for I/S/B/U/J into instr[31:7]
// Optional range/alignment checking of the immediate is enabled by defining IMM_RANGE_CHK_EN.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       Op,
    input  logic [31:0]      Imm,
    input  logic [24:0]      Base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      DataOut,
    output logic             out_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] enc_count
);

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_BAD = 3'd5
    } fmt_t;

    function automatic fmt_t decode_fmt(input logic [4:0] op);
        case (op)
            5'b00000, 5'b00100, 5'b11001: decode_fmt = FMT_I;
            5'b01000:                     decode_fmt = FMT_S;
            5'b11000:                     decode_fmt = FMT_B;
            5'b01101, 5'b00101:           decode_fmt = FMT_U;
            5'b11011:                     decode_fmt = FMT_J;
            default:                      decode_fmt = FMT_BAD;
        endcase
    endfunction

    logic             r_s1_v;
    fmt_t             r_s1_fmt;
    logic [31:0]      r_s1_imm;
    logic [24:0]      r_s1_base;
    logic             r_s2_v;
    logic [24:0]      r_s2_data;
    logic             r_s2_err;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s1_adv;
    logic             w_s2_adv;
    logic             w_xfer;
    logic [31:7]      w_instr;
    logic             w_fmt_err;
    logic             w_rng_err;

    // A stage may load when it is empty or its contents move on this cycle.
    assign w_s2_adv  = !r_s2_v || out_ready;
    assign w_s1_adv  = !r_s1_v || w_s2_adv;
    assign w_xfer    = r_s2_v && out_ready;

    assign in_ready   = w_s1_adv;
    assign out_valid  = r_s2_v;
    assign DataOut    = r_s2_data;
    assign out_err    = r_s2_err;
    assign err_sticky = r_sticky;
    assign enc_count  = r_cnt;

    always_comb begin
        w_instr   = r_s1_base;
        w_fmt_err = 1'b0;
        case (r_s1_fmt)
            FMT_I: w_instr[31:20] = r_s1_imm[11:0];
            FMT_S: begin
                w_instr[31:25] = r_s1_imm[11:5];
                w_instr[11:7]  = r_s1_imm[4:0];
            end
            FMT_B: begin
                w_instr[31]    = r_s1_imm[12];
                w_instr[30:25] = r_s1_imm[10:5];
                w_instr[11:8]  = r_s1_imm[4:1];
                w_instr[7]     = r_s1_imm[11];
            end
            FMT_U: w_instr[31:12] = r_s1_imm[31:12];
            FMT_J: begin
                w_instr[31]    = r_s1_imm[20];
                w_instr[30:21] = r_s1_imm[10:1];
                w_instr[20]    = r_s1_imm[11];
                w_instr[19:12] = r_s1_imm[19:12];
            end
            default: w_fmt_err = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHK_EN
    logic signed [31:0] w_simm;
    assign w_simm = r_s1_imm;

    always_comb begin
        w_rng_err = 1'b0;
        case (r_s1_fmt)
            FMT_I, FMT_S: w_rng_err = (w_simm < -32'sd2048) || (w_simm > 32'sd2047);
            FMT_B: w_rng_err = (w_simm < -32'sd4096) || (w_simm > 32'sd4094) || r_s1_imm[0];
            FMT_U: w_rng_err = |r_s1_imm[11:0];
            FMT_J: w_rng_err = (w_simm < -32'sd1048576) || (w_simm > 32'sd1048574) || r_s1_imm[0];
            default: w_rng_err = 1'b0;
        endcase
    end
`else
    assign w_rng_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_v    <= 1'b0;
            r_s1_fmt  <= FMT_BAD;
            r_s1_imm  <= '0;
            r_s1_base <= '0;
        end else if (w_s1_adv) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_fmt  <= decode_fmt(Op);
                r_s1_imm  <= Imm;
                r_s1_base <= Base;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_v    <= 1'b0;
            r_s2_data <= '0;
            r_s2_err  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_data <= w_instr;
                r_s2_err  <= w_fmt_err || w_rng_err;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (r_s2_err) begin
                r_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - randomized and directed checks of imm_encoder against a field-mask model
module tb_imm_encoder;

    localparam int TB_CNT_W = 4;
`ifdef IMM_RANGE_CHK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [4:0]          Op = '0;
    logic [31:0]         Imm = '0;
    logic [24:0]         Base = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [24:0]         DataOut;
    logic                out_err;
    logic                err_sticky;
    logic [TB_CNT_W-1:0] enc_count;

    int errors = 0;
    int checks = 0;

    logic [25:0]         q[$];
    logic [TB_CNT_W-1:0] m_cnt = '0;
    logic                m_sticky = 1'b0;
    logic                prev_stall = 1'b0;
    logic [25:0]         prev_out = '0;

    imm_encoder #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Op(Op), .Imm(Imm), .Base(Base), .out_valid(out_valid), .out_ready(out_ready),
        .DataOut(DataOut), .out_err(out_err), .err_sticky(err_sticky), .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {err, instr[31:7]}: the immediate field image is masked into the base word.
    function automatic logic [25:0] model(input logic [4:0] op, input logic [31:0] imm, input logic [24:0] base);
        logic [31:0] m, f, ins;
        logic        e;
        longint      v;
        v = longint'($signed(imm));
        m = '0;
        f = '0;
        e = 1'b0;
        case (op)
            5'b00000, 5'b00100, 5'b11001: begin
                m = 32'hFFF0_0000; f = imm << 20;
                e = RC && (v < -2048 || v > 2047);
            end
            5'b01000: begin
                m = 32'hFE00_0F80;
                f = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                e = RC && (v < -2048 || v > 2047);
            end
            5'b11000: begin
                m = 32'hFE00_0F80;
                f = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
                e = RC && (v < -4096 || v > 4094 || (imm % 2) != 0);
            end
            5'b01101, 5'b00101: begin
                m = 32'hFFFF_F000; f = imm;
                e = RC && ((imm % 4096) != 0);
            end
            5'b11011: begin
                m = 32'hFFFF_F000;
                f = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000F_F000);
                e = RC && (v < -1048576 || v > 1048574 || (imm % 2) != 0);
            end
            default: e = 1'b1;
        endcase
        ins = ({base, 7'b0} & ~m) | (f & m);
        return {e, ins[31:7]};
    endfunction

    // Scoreboard: outputs sampled on the falling edge, handshakes that will complete at the next rise.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            m_cnt      = '0;
            m_sticky   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("enc_count", 64'(enc_count), 64'(m_cnt));
            chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
            chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_hold", 64'({out_err, DataOut}), 64'(prev_out));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("stale_beat", 64'(out_valid), 64'd0);
                end else begin
                    chk("dataout", 64'(DataOut), 64'(q[0][24:0]));
                    chk("out_err", 64'(out_err), 64'(q[0][25]));
                end
            end
            if (out_valid && out_ready && q.size() != 0) begin
                if (q[0][25]) m_sticky = 1'b1;
                void'(q.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_err, DataOut};
            if (in_valid && in_ready) q.push_back(model(Op, Imm, Base));
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
    endtask

    task automatic send_check(input string nm, input logic [4:0] op, input logic [31:0] imm,
                              input logic [24:0] base, input logic [24:0] exp_d, input logic exp_e);
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; Op = op; Imm = imm; Base = base;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_data"}, 64'(DataOut), 64'(exp_d));
        chk({nm, "_err"}, 64'(out_err), 64'(exp_e));
    endtask

    task automatic drain(input string nm);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        chk(nm, 64'(q.size()), 64'd0);
        @(negedge clk);
    endtask

    logic [31:0] bnd[16] = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095,
                             32'd4096, -32'sd4096, -32'sd4098, 32'd1048574, 32'd1048576,
                             -32'sd1048576, -32'sd1048578, 32'h1000, 32'hFFFF_F000, 32'h1001};
    logic [4:0]  ops[12] = '{5'b00000, 5'b00100, 5'b11001, 5'b01000, 5'b11000, 5'b01101,
                             5'b00101, 5'b11011, 5'b01100, 5'b11111, 5'b00011, 5'b11011};

    initial begin
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(DataOut), 64'd0);
        chk("rst_err", 64'(out_err), 64'd0);
        chk("rst_cnt", 64'(enc_count), 64'd0);
        chk("rst_sticky", 64'(err_sticky), 64'd0);
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Range vectors first so err_sticky reflects only them.
        send_check("rng_i", 5'b00000, 32'd2048, 25'd0, {12'h800, 13'd0}, RC);
        send_check("rng_b", 5'b11000, 32'd3, 25'd0, 25'h2, RC);
        send_check("rng_u", 5'b01101, 32'h1001, 25'd0, 25'h20, RC);
        @(negedge clk);
        chk("rng_sticky", 64'(err_sticky), 64'(RC));

        send_check("vec_i", 5'b00000, 32'h0000_00DB, 25'd0, 25'b000011011011_0000000000000, 1'b0);
        send_check("vec_s", 5'b01000, 32'hFFFF_FF3B, 25'd0, 25'b1111001_0000000000000_11011, 1'b0);
        send_check("vec_b", 5'b11000, 32'h0000_08BE, 25'd0, 25'b0_000101_0000000000000_1111_1, 1'b0);
        send_check("vec_u", 5'b01101, 32'hFFFF_F000, 25'd0, {20'hFFFFF, 5'd0}, 1'b0);
        send_check("vec_j", 5'b11011, 32'hFFFA_F614, 25'd0, 25'b1_1100001010_0_10101111_00000, 1'b0);
        send_check("vec_bad", 5'b01100, 32'h1234_5678, 25'h1ABCDEF, 25'h1ABCDEF, 1'b1);
        send_check("vec_ibase", 5'b00100, 32'hFFFF_FFFF, 25'h1FFFFFF, 25'h1FFFFFF, 1'b0);
        @(negedge clk);
        chk("bad_sticky", 64'(err_sticky), 64'd1);
        drain("drain_dir");

        // Backpressure: four back-to-back requests against a stalled output.
        do_reset();
        begin
            int sent;
            int cyc;
            logic acc;
            sent = 0; cyc = 0;
            @(posedge clk); #1;
            out_ready = 1'b0; in_valid = 1'b1;
            Op = ops[0]; Imm = 32'h100; Base = 25'h0;
            while (sent < 4 && cyc < 50) begin
                @(negedge clk);
                if (sent == 2 && !out_ready) chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
                acc = in_ready;
                @(posedge clk); #1;
                if (acc) begin
                    sent++;
                    if (sent < 4) begin
                        Op = ops[sent * 2]; Imm = 32'h100 + 32'(sent); Base = 25'(sent * 77);
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                cyc++;
                if (cyc == 5) out_ready = 1'b1;
            end
            chk("bp_sent", 64'(sent), 64'd4);
        end
        drain("drain_bp");
        chk("bp_count", 64'(enc_count), 64'd4);

        // Reset with both stages full and the output stalled.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; Op = 5'b01100; Imm = 32'd5; Base = 25'h55;
        @(posedge clk); #1 Op = 5'b11011; Imm = 32'd8;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        chk("ms_pre_valid", 64'(out_valid), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("ms_valid", 64'(out_valid), 64'd0);
        chk("ms_cnt", 64'(enc_count), 64'd0);
        chk("ms_sticky", 64'(err_sticky), 64'd0);
        chk("ms_data", 64'({out_err, DataOut}), 64'd0);
        @(negedge clk); #1 reset = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ms_in_ready", 64'(in_ready), 64'd1);
        repeat (4) @(posedge clk);

        // Randomized traffic, counter wraps several times at this width.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            Op   = ops[$urandom_range(0, 11)];
            Base = 25'($urandom);
            case ($urandom_range(0, 3))
                0: Imm = $urandom;
                1: Imm = 32'($urandom_range(0, 16383)) - 32'd8192;
                2: Imm = bnd[$urandom_range(0, 15)];
                default: Imm = $urandom & 32'hFFFF_F000;
            endcase
        end
        drain("drain_rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
